// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory SRAM controller: FSM states,
// default data-memory base and the byte-to-word address mapping.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } sram_state_e;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
    localparam int unsigned PHASE_CNT_W    = 4;

    // Out-of-range offsets wrap silently; only the low 17 word bits reach the SRAM.
    function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Phase timer: clear has priority over enable, tc_o flags the last cycle of a phase.
module sram_phase_counter
    import mem_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [PHASE_CNT_W-1:0] LAST = PHASE_CNT_W'(PHASE_CYCLES - 1);

    logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + PHASE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage controller that splits each 32-bit load/store into two
// 16-bit SRAM phases (low half, then high half) and stalls the pipeline meanwhile.
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR    = SRAM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    sram_state_e state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cnt_clr, cnt_en, tc;
    logic [16:0] word;

    assign word      = word_index(addr_q, BASE_ADDR);
    assign read_data = rdata_q;

    sram_phase_counter #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (tc)
    );

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        ready       = 1'b0;
        cnt_clr     = 1'b1;
        cnt_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_en || rd_en) begin
                    is_wr_d = wr_en;
                    addr_d  = address;
                    wdata_d = write_data;
                    state_d = ST_LOW;
                end else begin
                    ready = 1'b1;
                end
            end
            ST_LOW: begin
                cnt_en    = 1'b1;
                cnt_clr   = tc;
                sram_addr = {word, 1'b0};
                // Strobe released on the final phase cycle to hold address/data.
                if (is_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                    sram_we_n   = tc;
                end else if (tc) begin
                    rdata_d[15:0] = sram_dq_in;
                end
                if (tc) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_en    = 1'b1;
                cnt_clr   = tc;
                sram_addr = {word, 1'b1};
                if (is_wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                    sram_we_n   = tc;
                end else if (tc) begin
                    rdata_d[31:16] = sram_dq_in;
                end
                if (tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst) begin
            ready = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized load/store bench for sram_ctrl against a word-level memory model,
// plus a PHASE_CYCLES=1 instance for minimum-latency loads.
module tb_sram_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        wr_en1 = 1'b0, rd_en1 = 1'b0;
    logic [31:0] read_data1;
    logic        ready1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;
    logic        sram_dq_oe1, sram_we_n1;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [31:0] ref_rdata;
    int          we_cnt = 0, oe_cnt = 0, bus1_cnt = 0;
    logic [33:0] we_q[$];
    int          n_checks = 0, n_errors = 0;

    sram_ctrl #(.PHASE_CYCLES(P), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_ctrl #(.PHASE_CYCLES(1), .BASE_ADDR(BASE)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address),
        .write_data(write_data), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    assign sram_dq_in  = mem[sram_addr[9:0]];
    assign sram_dq_in1 = sram_addr1[15:0] ^ 16'hC3C3;

    function automatic logic [15:0] init_word(input int unsigned i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [17:0] low_sa(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return {off[16:0], 1'b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM model: writes land while the strobe is low, sampled mid-cycle.
    initial begin
        for (int unsigned i = 0; i < 1024; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!sram_we_n) begin
                    mem[sram_addr[9:0]] = sram_dq_out;
                    we_cnt++;
                    we_q.push_back({sram_addr, sram_dq_out});
                end
                if (sram_dq_oe) oe_cnt++;
                if (sram_dq_oe1 || !sram_we_n1) bus1_cnt++;
            end
        end
    end

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input bit idle_after);
        int lo, we0, oe0, q0;
        logic [17:0] sa;
        logic [9:0]  ix;
        sa  = low_sa(a);
        ix  = sa[9:0];
        we0 = we_cnt;
        oe0 = oe_cnt;
        q0  = we_q.size();
        wr_en = w; rd_en = r; address = a; write_data = d;
        if (w) begin
            ref_mem[ix]         = d[15:0];
            ref_mem[ix + 10'd1] = d[31:16];
        end else if (r) begin
            ref_rdata = {ref_mem[ix + 10'd1], ref_mem[ix]};
        end
        lo = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) break;
            lo++;
        end
        check("busy_cycles", 64'(lo), (w | r) ? 64'(2 * P + 1) : 64'd0);
        check("read_data", read_data, ref_rdata);
        check("we_low_cycles", 64'(we_cnt - we0), w ? 64'(2 * (P - 1)) : 64'd0);
        check("oe_cycles", 64'(oe_cnt - oe0), w ? 64'(2 * P) : 64'd0);
        if (w) begin
            check("wr_seq_len", 64'(we_q.size() - q0), 64'(2 * (P - 1)));
            if (we_q.size() == q0 + 2) begin
                check("wr_low", we_q[q0], {sa, d[15:0]});
                check("wr_high", we_q[q0 + 1], {sa | 18'd1, d[31:16]});
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        if (idle_after) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
            check("idle_bus", {sram_we_n, sram_dq_oe, sram_addr, sram_dq_out},
                  {1'b1, 1'b0, 18'd0, 16'd0});
            if (w) check("mem", {mem[ix + 10'd1], mem[ix]}, {ref_mem[ix + 10'd1], ref_mem[ix]});
            @(posedge clk); #1;
        end
    endtask

    task automatic load1(input logic [31:0] a);
        int lo, b0;
        logic [17:0] sa;
        sa = low_sa(a);
        b0 = bus1_cnt;
        address = a; rd_en1 = 1'b1;
        lo = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready1) break;
            lo++;
        end
        check("p1_busy", 64'(lo), 64'd3);
        check("p1_data", read_data1,
              {(sa[15:0] | 16'd1) ^ 16'hC3C3, sa[15:0] ^ 16'hC3C3});
        check("p1_bus_quiet", 64'(bus1_cnt - b0), 64'd0);
        check("p1_dq_out", sram_dq_out1, 0);
        @(posedge clk); #1;
        rd_en1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        ref_rdata = '0;

        #2;
        wr_en = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_bus", {sram_we_n, sram_dq_oe, sram_addr}, {1'b1, 1'b0, 18'd0});
        check("rst_rdata", read_data, 0);
        check("rst_ready1", ready1, 1);
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b1);
        access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 1'b1);
        access(1'b1, 1'b1, 32'd1032, 32'h0BADC0DE, 1'b1);
        access(1'b1, 1'b0, BASE + (32'd131077 << 2), 32'h13579BDF, 1'b1);
        access(1'b0, 1'b1, BASE + (32'd131077 << 2), 32'h0, 1'b1);
        access(1'b1, 1'b0, 32'd1020, 32'h2468ACE0, 1'b1);
        access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic        w, r;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = BASE + 32'(4 * $urandom_range(0, 255));
            access(w, r, a, $urandom, 1'($urandom_range(0, 1)));
        end

        // Abort a store during its high phase.
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hA5A55A5A;
        repeat (4) @(negedge clk);
        check("pre_rst_addr", sram_addr, 18'd9);
        check("pre_rst_we", sram_we_n, 0);
        #1 rst = 1'b1;
        #1;
        check("abort_we_n", sram_we_n, 1);
        check("abort_oe", sram_dq_oe, 0);
        check("abort_rdata", read_data, 0);
        check("abort_ready", ready, 1);
        ref_mem[8] = 16'h5A5A;
        ref_mem[9] = 16'hA5A5;
        ref_rdata  = '0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b1);

        load1(32'd1028);
        load1(32'd1400);
        load1(BASE + 32'(4 * $urandom_range(0, 4000)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: PHASE_CYCLES, default 2, clocks each SRAM half-word phase is held; legal range 1-15.
REQ-002 Parameter: BASE_ADDR, default 32'd1024, data-memory base subtracted from the ALU address.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  MEM-stage store request (MEM_W_EN).
REQ-006 rd_en  in  1  MEM-stage load request (MEM_R_EN).
REQ-007 address  in  32  byte address from the ALU result.
REQ-008 write_data  in  32  store data.
REQ-009 read_data  out  32  load data, registered, consumed by the MEM_WB data input.
REQ-010 ready  out  1  high when the pipeline may advance; the pipeline freezes on ~ready.
REQ-011 sram_addr  out  18  SRAM half-word address.
REQ-012 sram_dq_out  out  16  SRAM write data.
REQ-013 sram_dq_oe  out  1  output-enable for sram_dq_out; the top level builds the tristate.
REQ-014 sram_dq_in  in  16  SRAM read data.
REQ-015 sram_we_n  out  1  SRAM write strobe, active-low.

Function
REQ-016 FSM states: IDLE, LOW, HIGH, DONE. A phase counter counts 0..PHASE_CYCLES-1.
REQ-017 IDLE transitions:
- wr_en|rd_en high: latch op, address and write_data; go to LOW; clear the counter.
- Otherwise: remain in IDLE.
REQ-018 LOW transitions: after PHASE_CYCLES clocks, go to HIGH and clear the counter.
REQ-019 HIGH transitions: after PHASE_CYCLES clocks, go to DONE.
REQ-020 DONE transitions: return to IDLE unconditionally. Requests present in DONE are not accepted.
REQ-021 Address mapping: word = (latched address - BASE_ADDR) >> 2.
- sram_addr = {word[16:0],1'b0} in LOW.
- sram_addr = {word[16:0],1'b1} in HIGH.
- Out-of-range addresses are truncated and not flagged.
REQ-022 Write path:
- LOW drives write_data[15:0] on sram_dq_out; HIGH drives write_data[31:16].
- sram_dq_oe is high in LOW and HIGH.
- sram_we_n is low in LOW and HIGH except the last counter cycle of each phase, so there is one cycle of address/data hold.
REQ-023 Read path:
- sram_dq_oe and sram_we_n are inactive (0 and 1).
- read_data[15:0] is captured from sram_dq_in on the last LOW cycle.
- read_data[31:16] is captured on the last HIGH cycle.
REQ-024 read_data holds its value until the next read overwrites it; writes do not modify it.
REQ-025 ready is combinational.
- 1 in IDLE when wr_en=rd_en=0.
- 1 in DONE.
- 0 in every other case, including the IDLE cycle in which a request arrives.
REQ-026 Latency: a request busies the block for 2*PHASE_CYCLES+1 cycles, ending with ready=1 in DONE. With the default parameter, ready is low for exactly 5 cycles.
REQ-027 When wr_en and rd_en are both high, the access is a write and read_data is unchanged.
REQ-028 Outside LOW and HIGH: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.

Reset
REQ-029 rst asserted at any time forces the following, aborting any access in progress without completing it:
- state=IDLE, counter=0
- read_data=0
- latched registers=0
- sram_we_n=1, sram_dq_oe=0
REQ-030 During reset ready=1.

Structure
REQ-031 The state enum and the BASE_ADDR default live in the shared package (mem_pkg); PHASE_CYCLES stays a module parameter.
REQ-032 One sub-module, sram_phase_counter, is natural: a clear/enable counter with a terminal-count output.

Verification
REQ-033 Store: address=1028, write_data=32'hDEADBEEF. Required:
- sram_addr=2 with dq_out=16'hBEEF.
- Then sram_addr=3 with dq_out=16'hDEAD.
- sram_we_n low 1 cycle per phase.
- ready low 5 cycles.
REQ-034 Load: address=1028, sram model returns 16'h5678 at address 2 and 16'h1234 at address 3. Required: read_data=32'h12345678 in DONE; oe never high.
REQ-035 Back-to-back load then store, with the requester holding each request until ready=1:
- Exactly two accesses occur, with no duplicate access from DONE.
- read_data stays 32'h12345678 after the store.
REQ-036 Simultaneous: wr_en=rd_en=1, address=1032. Required: write to sram_addr 4/5; read_data unchanged.
REQ-037 Reset mid-operation: assert rst in the HIGH state. Required in the same cycle:
- sram_we_n=1, oe=0, read_data=0, ready=1.
- The next request starts cleanly from LOW.
REQ-038 PHASE_CYCLES=1: single load. Required: ready low exactly 3 cycles; data captured correctly.
